// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_pkg
//  Description : Shared types for the PWM block family (duty ramp, pwm core).
//  Revision    : 1.0 - initial release
// ============================================================================
package pwm_pkg;

  // Ramp controller state encoding, shared with the pwm core.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2
  } ramp_state_e;

endpackage : pwm_pkg
`default_nettype wire

// File: rtl/pwm_duty_ramp_if.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_duty_ramp_if
//  Description : Target request handshake (target/step/rate with valid/ready).
//  Revision    : 1.0 - initial release
// ============================================================================
interface pwm_duty_ramp_if #(
  parameter int COUNTER_WIDTH = 8,
  parameter int RATE_WIDTH    = 8
);
  logic [COUNTER_WIDTH-1:0] target_i;
  logic [COUNTER_WIDTH-1:0] step_i;
  logic [RATE_WIDTH-1:0]    rate_i;
  logic                     target_valid_i;
  logic                     target_ready_o;

  // Requester side: presents a new target and waits for ready.
  modport master (
    output target_i, step_i, rate_i, target_valid_i,
    input  target_ready_o
  );

  // Ramp controller side.
  modport slave (
    input  target_i, step_i, rate_i, target_valid_i,
    output target_ready_o
  );
endinterface : pwm_duty_ramp_if
`default_nettype wire

// File: rtl/pwm_phase_counter.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_phase_counter
//  Description : Free-running PWM phase counter, advances while enabled and
//                wraps naturally from all-ones to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_phase_counter #(
  parameter int WIDTH = 8
) (
  input  wire logic             clk_i,
  input  wire logic             a_rst_n_i,
  input  wire logic             enable_i,
  output logic [WIDTH-1:0]      phase_o
);

  localparam logic [WIDTH-1:0] PHASE_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] phase_q;
  logic [WIDTH-1:0] phase_d;

  // Next phase: count up while enabled, otherwise hold.
  always_comb begin
    phase_d = phase_q;
    if (enable_i) begin
      phase_d = phase_q + PHASE_ONE;
    end
  end

  // Phase register.
  always_ff @(posedge clk_i or negedge a_rst_n_i) begin
    if (!a_rst_n_i) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign phase_o = phase_q;

endmodule : pwm_phase_counter
`default_nettype wire

// File: rtl/pwm_duty_ramp.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_duty_ramp
//  Description : Ramps a PWM duty value toward a requested target in
//                saturating steps, one step every rate_i PWM periods. Duty
//                only changes on the cycle the phase counter wraps.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_duty_ramp
  import pwm_pkg::*;
#(
  parameter int COUNTER_WIDTH = 8,
  parameter int RATE_WIDTH    = 8
) (
  input  wire logic                     clk_i,
  input  wire logic                     a_rst_n_i,
  input  wire logic                     enable_i,
  input  wire logic                     abort_i,
  pwm_duty_ramp_if.slave                tgt_if,
  output logic [COUNTER_WIDTH-1:0]      duty_o,
  output logic                          busy_o,
  output logic                          done_o
);

  localparam int W = COUNTER_WIDTH;
  localparam int R = RATE_WIDTH;
  localparam logic [R-1:0] RATE_ONE = {{(R-1){1'b0}}, 1'b1};

  ramp_state_e  state_q,    state_d;
  logic [W-1:0] duty_q,     duty_d;
  logic [W-1:0] target_q,   target_d;
  logic [W-1:0] step_q,     step_d;
  logic [R-1:0] reload_q,   reload_d;
  logic [R-1:0] rate_cnt_q, rate_cnt_d;
  logic         done_q,     done_d;

  logic [W-1:0] phase;
  logic         boundary;
  logic [R-1:0] reload_in;
  logic [W:0]   sum;
  logic [W:0]   diff;
  logic [W-1:0] stepped;

  pwm_phase_counter #(.WIDTH(W)) u_phase (
    .clk_i     (clk_i),
    .a_rst_n_i (a_rst_n_i),
    .enable_i  (enable_i),
    .phase_o   (phase)
  );

  // A boundary is the enabled cycle on which the phase wraps to zero.
  assign boundary  = enable_i && (phase == '1);
  // A rate of 0 behaves like 1: reload value is max(rate,1)-1.
  assign reload_in = (tgt_if.rate_i == '0) ? '0 : (tgt_if.rate_i - RATE_ONE);

  // Candidate duty after one step, computed one bit wider and clamped at the target.
  always_comb begin
    sum     = {1'b0, duty_q} + {1'b0, step_q};
    diff    = {1'b0, duty_q} - {1'b0, step_q};
    stepped = target_q;
    if (step_q == '0) begin
      stepped = target_q;
    end else if (state_q == RAMP_UP) begin
      stepped = (sum >= {1'b0, target_q}) ? target_q : sum[W-1:0];
    end else begin
      // diff[W] set means the subtraction went below zero.
      stepped = (diff[W] || (diff[W-1:0] <= target_q)) ? target_q : diff[W-1:0];
    end
  end

  // Next-state and datapath update for the ramp FSM; abort overrides everything.
  always_comb begin
    state_d    = state_q;
    duty_d     = duty_q;
    target_d   = target_q;
    step_d     = step_q;
    reload_d   = reload_q;
    rate_cnt_d = rate_cnt_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (tgt_if.target_valid_i) begin
          target_d   = tgt_if.target_i;
          step_d     = tgt_if.step_i;
          reload_d   = reload_in;
          rate_cnt_d = reload_in;
          if (tgt_if.target_i > duty_q) begin
            state_d = RAMP_UP;
          end else if (tgt_if.target_i < duty_q) begin
            state_d = RAMP_DOWN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RAMP_UP, RAMP_DOWN: begin
        if (boundary) begin
          if (rate_cnt_q == '0) begin
            duty_d     = stepped;
            rate_cnt_d = reload_q;
            if (stepped == target_q) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            rate_cnt_d = rate_cnt_q - RATE_ONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (abort_i) begin
      state_d = IDLE;
      duty_d  = duty_q;
      done_d  = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge a_rst_n_i) begin
    if (!a_rst_n_i) begin
      state_q    <= IDLE;
      duty_q     <= '0;
      target_q   <= '0;
      step_q     <= '0;
      reload_q   <= '0;
      rate_cnt_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      duty_q     <= duty_d;
      target_q   <= target_d;
      step_q     <= step_d;
      reload_q   <= reload_d;
      rate_cnt_q <= rate_cnt_d;
      done_q     <= done_d;
    end
  end

  assign duty_o                = duty_q;
  assign done_o                = done_q;
  assign busy_o                = (state_q == RAMP_UP) || (state_q == RAMP_DOWN);
  assign tgt_if.target_ready_o = (state_q == IDLE);

endmodule : pwm_duty_ramp
`default_nettype wire

// File: tb/tb_pwm_duty_ramp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pwm_duty_ramp
//  Description : Self-checking bench for pwm_duty_ramp with a behavioural
//                reference model (boundary counting, integer min/max steps).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_duty_ramp;

  localparam int W = 8;
  localparam int R = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       abort;
  logic [7:0] duty;
  logic       busy;
  logic       done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pwm_duty_ramp_if #(.COUNTER_WIDTH(W), .RATE_WIDTH(R)) tif ();

  pwm_duty_ramp #(.COUNTER_WIDTH(W), .RATE_WIDTH(R)) dut (
    .clk_i     (clk),
    .a_rst_n_i (rst_n),
    .enable_i  (enable),
    .abort_i   (abort),
    .tgt_if    (tif),
    .duty_o    (duty),
    .busy_o    (busy),
    .done_o    (done)
  );

  // Reference model: a step lands on every k-th PWM period boundary after the
  // request, k = max(rate,1); steps are plain integer min/max toward target.
  int m_phase, m_duty, m_tgt, m_stp, m_k, m_nb;
  bit m_busy, m_up, m_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_duty = 0; m_tgt = 0; m_stp = 0; m_k = 1; m_nb = 0;
      m_busy = 0; m_up = 0; m_done = 0;
    end else begin
      bit bnd;
      bnd = enable && (m_phase == 255);
      if (enable) m_phase = (m_phase + 1) % 256;
      m_done = 0;
      if (abort) begin
        m_busy = 0;
      end else if (!m_busy) begin
        if (tif.target_valid_i) begin
          m_tgt = tif.target_i;
          m_stp = tif.step_i;
          m_k   = (tif.rate_i == 0) ? 1 : int'(tif.rate_i);
          m_nb  = 0;
          if (m_tgt == m_duty) m_done = 1;
          else begin
            m_busy = 1;
            m_up   = (m_tgt > m_duty);
          end
        end
      end else if (bnd) begin
        m_nb++;
        if (m_nb % m_k == 0) begin
          if (m_stp == 0) m_duty = m_tgt;
          else if (m_up) m_duty = (m_duty + m_stp > m_tgt) ? m_tgt : m_duty + m_stp;
          else m_duty = (m_duty - m_stp < m_tgt) ? m_tgt : m_duty - m_stp;
          if (m_duty == m_tgt) begin
            m_busy = 0;
            m_done = 1;
          end
        end
      end
    end
  end

  task automatic handshake(input int t, input int s, input int r);
    int tv, sv, rv;
    tv = t; sv = s; rv = r;
    tif.target_i       = tv[7:0];
    tif.step_i         = sv[7:0];
    tif.rate_i         = rv[7:0];
    tif.target_valid_i = 1'b1;
    @(negedge clk);
    tif.target_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; abort = 1'b0;
    tif.target_i = '0; tif.step_i = '0; tif.rate_i = '0; tif.target_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (duty !== 8'd0) begin failures++; $display("FAIL reset_duty got=%0d exp=0", duty); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (tif.target_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", tif.target_ready_o); end
    rst_n  = 1'b1;
    enable = 1'b1;
  endtask

  task automatic test_ramp_up();
    logic [7:0] prev;
    bit         prev_busy;
    int         seen[$];
    int         dcnt = 0;
    handshake(40, 16, 1);
    prev = duty; prev_busy = busy;
    for (int c = 0; c < 1100; c++) begin
      @(negedge clk);
      checks++;
      if (duty !== m_duty[7:0] || busy !== m_busy || done !== m_done || tif.target_ready_o !== !m_busy) begin
        failures++;
        $display("FAIL up_model t=%0t duty=%0d exp=%0d busy=%b exp=%b done=%b exp=%b", $time, duty, m_duty, busy, m_busy, done, m_done);
      end
      if (duty !== prev) begin seen.push_back(int'(duty)); prev = duty; end
      if (done === 1'b1) begin
        dcnt++;
        checks++;
        if (busy !== 1'b0 || prev_busy !== 1'b1) begin
          failures++; $display("FAIL up_busy_fall busy=%b prev=%b exp=0/1", busy, prev_busy);
        end
      end
      prev_busy = busy;
    end
    checks++;
    if (seen.size() != 3 || seen[0] != 16 || seen[1] != 32 || seen[2] != 40) begin
      failures++; $display("FAIL up_sequence got n=%0d first=%0d exp 16,32,40", seen.size(), (seen.size() > 0) ? seen[0] : -1);
    end
    checks++; if (dcnt != 1) begin failures++; $display("FAIL up_done_count got=%0d exp=1", dcnt); end
  endtask

  task automatic test_ramp_down();
    logic [7:0] prev;
    int seen[$], at[$];
    int dcnt = 0, bcnt = 0;
    handshake(0, 30, 2);
    prev = duty;
    for (int c = 0; c < 1300; c++) begin
      @(negedge clk);
      if (m_phase == 0) bcnt++;
      checks++;
      if (duty !== m_duty[7:0] || busy !== m_busy || done !== m_done) begin
        failures++;
        $display("FAIL down_model t=%0t duty=%0d exp=%0d busy=%b exp=%b done=%b exp=%b", $time, duty, m_duty, busy, m_busy, done, m_done);
      end
      if (duty !== prev) begin seen.push_back(int'(duty)); at.push_back(bcnt); prev = duty; end
      if (done === 1'b1) dcnt++;
    end
    checks++;
    if (seen.size() != 2 || seen[0] != 10 || seen[1] != 0 || at[0] != 2 || at[1] != 4) begin
      failures++; $display("FAIL down_sequence got n=%0d first=%0d@%0d exp 10@2,0@4", seen.size(),
                           (seen.size() > 0) ? seen[0] : -1, (at.size() > 0) ? at[0] : -1);
    end
    checks++; if (dcnt != 1) begin failures++; $display("FAIL down_done_count got=%0d exp=1", dcnt); end
  endtask

  task automatic test_step_zero();
    logic [7:0] prev;
    int first_at = -1, dcnt = 0, bcnt = 0;
    handshake(200, 0, 0);
    prev = duty;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (m_phase == 0) bcnt++;
      if (duty !== prev && first_at < 0) first_at = bcnt;
      prev = duty;
      if (done === 1'b1) dcnt++;
    end
    checks++; if (duty !== 8'd200 || first_at != 1) begin failures++; $display("FAIL step_zero duty=%0d at=%0d exp=200 at 1", duty, first_at); end
    checks++; if (dcnt != 1) begin failures++; $display("FAIL step_zero_done got=%0d exp=1", dcnt); end
  endtask

  task automatic test_equal_target();
    handshake(200, 5, 3);
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL equal_done got=%b exp=1", done); end
    checks++; if (busy !== 1'b0 || tif.target_ready_o !== 1'b1) begin failures++; $display("FAIL equal_idle busy=%b ready=%b exp=0/1", busy, tif.target_ready_o); end
    checks++; if (duty !== 8'd200) begin failures++; $display("FAIL equal_duty got=%0d exp=200", duty); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL equal_done_width got=%b exp=0", done); end
  endtask

  task automatic test_abort_and_hold();
    int dcnt = 0, bad = 0;
    handshake(0, 50, 1);
    for (int c = 0; c < 300 && duty !== 8'd150; c++) @(negedge clk);
    for (int c = 0; c < 300 && m_phase != 255; c++) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++; if (duty !== 8'd150) begin failures++; $display("FAIL abort_duty got=%0d exp=150", duty); end
    checks++; if (busy !== 1'b0 || tif.target_ready_o !== 1'b1) begin failures++; $display("FAIL abort_idle busy=%b ready=%b exp=0/1", busy, tif.target_ready_o); end
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (done === 1'b1) dcnt++;
      if (duty !== 8'd150) bad++;
    end
    checks++; if (dcnt != 0 || bad != 0) begin failures++; $display("FAIL abort_quiet done=%0d moved=%0d exp=0/0", dcnt, bad); end
    // Start a new ramp, then freeze everything with enable low.
    handshake(0, 50, 1);
    enable = 1'b0;
    bad = 0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (duty !== 8'd150 || busy !== 1'b1 || done !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL enable_hold changed=%0d exp=0", bad); end
    enable = 1'b1;
    for (int c = 0; c < 850; c++) begin
      @(negedge clk);
      checks++;
      if (duty !== m_duty[7:0] || busy !== m_busy || done !== m_done) begin
        failures++;
        $display("FAIL resume_model t=%0t duty=%0d exp=%0d busy=%b exp=%b done=%b exp=%b", $time, duty, m_duty, busy, m_busy, done, m_done);
      end
    end
    checks++; if (duty !== 8'd0) begin failures++; $display("FAIL resume_final got=%0d exp=0", duty); end
  endtask

  task automatic test_reset_midramp();
    handshake(255, 40, 1);
    for (int c = 0; c < 300 && duty === 8'd0; c++) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (duty !== 8'd0 || busy !== 1'b0 || done !== 1'b0 || tif.target_ready_o !== 1'b1) begin
      failures++; $display("FAIL async_reset duty=%0d busy=%b done=%b ready=%b exp=0/0/0/1", duty, busy, done, tif.target_ready_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      checks++;
      if (duty !== m_duty[7:0] || busy !== m_busy || done !== m_done) begin
        failures++; $display("FAIL post_reset_model duty=%0d exp=%0d busy=%b done=%b", duty, m_duty, busy, done);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 5; n++) begin
      int t, s, r;
      t = $urandom_range(0, 255);
      s = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(48, 255);
      r = $urandom_range(0, 3);
      handshake(t, s, r);
      for (int c = 0; c < 7000; c++) begin
        enable = ($urandom_range(0, 7) != 0);
        @(negedge clk);
        checks++;
        if (duty !== m_duty[7:0] || busy !== m_busy || done !== m_done || tif.target_ready_o !== !m_busy) begin
          failures++;
          $display("FAIL rand_model n=%0d t=%0t duty=%0d exp=%0d busy=%b exp=%b done=%b exp=%b", n, $time, duty, m_duty, busy, m_busy, done, m_done);
        end
        if (!m_busy) break;
      end
      checks++; if (m_busy || busy !== 1'b0) begin failures++; $display("FAIL rand_timeout n=%0d busy=%b exp=0", n, busy); end
      enable = 1'b1;
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_ramp_down();
    test_step_zero();
    test_equal_target();
    test_abort_and_hold();
    test_reset_midramp();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_pwm_duty_ramp
`default_nettype wire

// File: doc/pwm_duty_ramp.md
PWM_DUTY_RAMP -- requirements
Module: pwm_duty_ramp

Interface
REQ-001 Parameter COUNTER_WIDTH, default 8: width of duty values and of the internal PWM phase counter (W).
REQ-002 Parameter RATE_WIDTH, default 8: width of the periods-per-step rate input (R).
REQ-003 clk_i  input  1  single clock; all logic on its rising edge.
REQ-004 a_rst_n_i  input  1  reset, asynchronous assert, active-low.
REQ-005 enable_i  input  1  advances the phase counter; must be the same signal that drives the downstream pwm enable_i.
REQ-006 target_i  input  W  requested final duty value.
REQ-007 step_i  input  W  duty increment/decrement per step; captured with target_i.
REQ-008 rate_i  input  R  PWM periods per step; captured with target_i; 0 is treated as 1.
REQ-009 target_valid_i  input  1  target/step/rate valid.
REQ-010 target_ready_o  output  1  block can accept a new target.
REQ-011 abort_i  input  1  stop ramping and hold the present duty.
REQ-012 duty_o  output  W  registered duty value; drives the pwm req_value_i.
REQ-013 busy_o  output  1  ramp in progress.
REQ-014 done_o  output  1  one-cycle pulse when duty_o reaches the target.

Function
REQ-015 The phase counter SHALL be W bits, increment by 1 on each cycle with enable_i=1, and wrap from 2^W-1 to 0.
REQ-016 A boundary SHALL occur on a cycle with enable_i=1 and phase = 2^W-1; duty_o changes only at a boundary, so the new value takes effect with the phase wrap.
REQ-017 The FSM SHALL have states IDLE, RAMP_UP and RAMP_DOWN.
REQ-018 target_ready_o SHALL be 1 exactly in IDLE; a handshake (valid and ready both 1) SHALL capture target_i, step_i and rate_i, and load the rate counter with max(rate_i,1)-1.
REQ-019 On handshake, next state SHALL be RAMP_UP if target>duty_o, RAMP_DOWN if target<duty_o; if target=duty_o the state SHALL stay IDLE and done_o SHALL pulse on the next cycle.
REQ-020 In RAMP states, at each boundary with rate counter=0, a step SHALL be applied and the rate counter reloaded; otherwise the rate counter decrements at each boundary.
REQ-021 A step SHALL be computed at W+1 bits and saturate at the target: up: duty=min(duty+step,target); down: duty=max(duty-step,target), with no wrap below 0 or above 2^W-1.
REQ-022 A captured step of 0 SHALL set duty_o to the target at the first applied step.
REQ-023 When the applied step makes duty_o equal the target, the FSM SHALL enter IDLE and done_o SHALL be 1 for exactly the following cycle.
REQ-024 busy_o SHALL be 1 exactly in RAMP_UP or RAMP_DOWN.
REQ-025 abort_i=1 SHALL force IDLE on the next edge, hold duty_o, and produce no done_o; abort_i has priority over a same-cycle step.
REQ-026 target_valid_i without ready SHALL be ignored; inputs are sampled only at a handshake.
REQ-027 With enable_i=0, phase, rate counter and duty_o SHALL hold.

Reset
REQ-028 While a_rst_n_i=0: phase=0, rate counter=0, captured registers=0, duty_o=0, state=IDLE, busy_o=0, done_o=0, target_ready_o=1.
REQ-029 Reset mid-ramp SHALL abandon the ramp immediately with no done_o; release is synchronous to clk_i.

Structure
REQ-030 State encodings (IDLE=0, RAMP_UP=1, RAMP_DOWN=2) SHALL live in a shared package pwm_pkg.
REQ-031 The phase counter SHALL be a sub-module pwm_phase_counter, instantiated here and able to be reused by pwm.
REQ-032 All outputs SHALL be registered, except target_ready_o and busy_o, which are decoded from state.

Verification (W=8, R=8)
REQ-033 From reset, enable_i=1, handshake target=40, step=16, rate=1 -> duty_o 16, 32, 40 at the first three boundaries; done_o pulses once; busy_o falls at the same edge.
REQ-034 With duty_o=40, target=0, step=30, rate=2 -> duty_o 10 after the 2nd boundary, then 0 after the 4th; done_o pulses; no underflow.
REQ-035 step=0, target=200, rate=0 -> duty_o=200 at the first boundary; done_o pulses.
REQ-036 Handshake target=duty_o -> state stays IDLE; done_o pulses the next cycle; duty_o unchanged.
REQ-037 abort_i asserted on a boundary cycle mid-ramp -> duty_o holds its value, state is IDLE, no done_o; enable_i=0 for 500 cycles -> nothing changes.
REQ-038 a_rst_n_i asserted asynchronously mid-ramp -> all outputs at reset values before the next clk_i edge.
